// File: rtl/pkt_buf_pkg.sv
// Shared types for the commit-pointer packet buffer:
// write FSM states and the stored word layout.
package pkt_buf_pkg;

    localparam int PKT_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_PKT  = 2'd1,
        DISCARD = 2'd2
    } wr_state_e;

    typedef struct packed {
        logic                  eop;
        logic [PKT_DATA_W-1:0] data;
    } pkt_word_t;

endpackage

// File: rtl/pkt_buf_mem.sv
// Simple dual-port RAM for the packet buffer:
// one write port, one registered read port.
module pkt_buf_mem #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16384
) (
    input  logic                     clk,
    input  logic                     hw_rst,
    input  logic                     sw_rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; output register clears on either reset.
    always_ff @(posedge clk or negedge hw_rst) begin
        if (!hw_rst) begin
            r_rdata <= '0;
        end else if (sw_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pkt_commit_buffer.sv
// Store-and-forward packet buffer with commit pointer rollback.
// Optional PKT_BUF_STATS_EN adds saturating drop_cnt / ovf_cnt outputs.
module pkt_commit_buffer
    import pkt_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16384,
    parameter int TH_WIDTH   = 5
) (
    input  logic                   clk,
    input  logic                   hw_rst,
    input  logic                   sw_rst,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_sop,
    input  logic                   wr_eop,
    input  logic                   wr_drop,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_eop,
    output logic                   rd_valid,
    input  logic [TH_WIDTH-1:0]    af_thresh,
    input  logic [TH_WIDTH-1:0]    ae_thresh,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] wr_lvl,
    output logic [$clog2(DEPTH):0] rd_lvl,
    output logic [$clog2(DEPTH):0] pkt_cnt,
    output logic                   overflow,
    output logic                   underflow,
`ifdef PKT_BUF_STATS_EN
    output logic [15:0]            drop_cnt,
    output logic [15:0]            ovf_cnt,
`endif
    output logic                   sop_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (((AW + 1) > TH_WIDTH) ? (AW + 1) : TH_WIDTH) + 1;
    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    wr_state_e r_state;
    wr_state_e w_state_nxt;

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_cmt_ptr;
    logic [AW:0] r_rd_ptr;
    logic [AW:0] r_pkt_cnt;
    logic [AW:0] w_wr_ptr_nxt;
    logic [AW:0] w_cmt_ptr_nxt;

    logic        r_rd_valid;
    logic        r_ovf;
    logic        r_udf;
    logic        r_sop_err;

    logic        w_full;
    logic        w_cmt_full;
    logic        w_empty;
    logic        w_rd_acc;
    logic        w_commit;
    logic        w_ovf;
    logic        w_sop_err;
    logic        w_rollback;
    logic        w_pkt_dec;

    logic               w_mem_we;
    logic [AW-1:0]      w_mem_waddr;
    logic [DATA_WIDTH:0] w_mem_q;

    logic [CW-1:0] w_af_sum;

    assign w_full = (r_wr_ptr[AW] != r_rd_ptr[AW])
                 && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_cmt_full = (r_cmt_ptr[AW] != r_rd_ptr[AW])
                     && (r_cmt_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty  = (r_cmt_ptr == r_rd_ptr);
    assign w_rd_acc = rd_en && !w_empty;

    // Write FSM: next state, pointer moves, RAM write and error pulses.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_cmt_ptr_nxt = r_cmt_ptr;
        w_mem_we      = 1'b0;
        w_mem_waddr   = r_wr_ptr[AW-1:0];
        w_commit      = 1'b0;
        w_ovf         = 1'b0;
        w_sop_err     = 1'b0;
        w_rollback    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (wr_en) begin
                    if (!wr_sop) begin
                        w_sop_err = 1'b1;
                    end else if (w_full) begin
                        w_ovf = 1'b1;
                        if (!wr_eop) begin
                            w_state_nxt = DISCARD;
                        end
                    end else begin
                        w_mem_we     = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                        if (wr_eop) begin
                            w_cmt_ptr_nxt = r_wr_ptr + PTR_ONE;
                            w_commit      = 1'b1;
                        end else begin
                            w_state_nxt = IN_PKT;
                        end
                    end
                end
            end
            IN_PKT: begin
                if (wr_drop) begin
                    w_wr_ptr_nxt = r_cmt_ptr;
                    w_rollback   = 1'b1;
                    w_state_nxt  = IDLE;
                end else if (wr_en && wr_sop) begin
                    // Restart: old packet vanishes, new one begins at cmt_ptr.
                    w_sop_err    = 1'b1;
                    w_rollback   = 1'b1;
                    w_wr_ptr_nxt = r_cmt_ptr;
                    if (w_cmt_full) begin
                        w_ovf       = 1'b1;
                        w_state_nxt = wr_eop ? IDLE : DISCARD;
                    end else begin
                        w_mem_we     = 1'b1;
                        w_mem_waddr  = r_cmt_ptr[AW-1:0];
                        w_wr_ptr_nxt = r_cmt_ptr + PTR_ONE;
                        if (wr_eop) begin
                            w_cmt_ptr_nxt = r_cmt_ptr + PTR_ONE;
                            w_commit      = 1'b1;
                            w_state_nxt   = IDLE;
                        end
                    end
                end else if (wr_en && w_full) begin
                    w_ovf        = 1'b1;
                    w_rollback   = 1'b1;
                    w_wr_ptr_nxt = r_cmt_ptr;
                    w_state_nxt  = wr_eop ? IDLE : DISCARD;
                end else if (wr_en) begin
                    w_mem_we     = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                    if (wr_eop) begin
                        w_cmt_ptr_nxt = r_wr_ptr + PTR_ONE;
                        w_commit      = 1'b1;
                        w_state_nxt   = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (wr_en && wr_eop) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Write-side state: FSM, write and commit pointers.
    always_ff @(posedge clk or negedge hw_rst) begin
        if (!hw_rst) begin
            r_state   <= IDLE;
            r_wr_ptr  <= '0;
            r_cmt_ptr <= '0;
        end else if (sw_rst) begin
            r_state   <= IDLE;
            r_wr_ptr  <= '0;
            r_cmt_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_cmt_ptr <= w_cmt_ptr_nxt;
        end
    end

    // Read pointer, read-valid and registered error pulses.
    always_ff @(posedge clk or negedge hw_rst) begin
        if (!hw_rst) begin
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_sop_err  <= 1'b0;
        end else if (sw_rst) begin
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_sop_err  <= 1'b0;
        end else begin
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_rd_valid <= w_rd_acc;
            r_ovf      <= w_ovf;
            r_udf      <= rd_en && w_empty;
            r_sop_err  <= w_sop_err;
        end
    end

    // EOP of a read word is known once the RAM output register holds it.
    assign w_pkt_dec = r_rd_valid && w_mem_q[DATA_WIDTH];

    // Committed packet count: +1 on commit, -1 when an EOP word leaves.
    always_ff @(posedge clk or negedge hw_rst) begin
        if (!hw_rst) begin
            r_pkt_cnt <= '0;
        end else if (sw_rst) begin
            r_pkt_cnt <= '0;
        end else if (w_commit && !w_pkt_dec) begin
            r_pkt_cnt <= r_pkt_cnt + PTR_ONE;
        end else if (w_pkt_dec && !w_commit) begin
            r_pkt_cnt <= r_pkt_cnt - PTR_ONE;
        end
    end

    pkt_buf_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .hw_rst  (hw_rst),
        .sw_rst  (sw_rst),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata ({wr_eop, wr_data}),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_mem_q)
    );

`ifdef PKT_BUF_STATS_EN
    logic [15:0] r_drop_cnt;
    logic [15:0] r_ovf_cnt;

    // Saturating rollback and overflow statistics.
    always_ff @(posedge clk or negedge hw_rst) begin
        if (!hw_rst) begin
            r_drop_cnt <= '0;
            r_ovf_cnt  <= '0;
        end else if (sw_rst) begin
            r_drop_cnt <= '0;
            r_ovf_cnt  <= '0;
        end else begin
            if (w_rollback && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            if (w_ovf && (r_ovf_cnt != 16'hFFFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign ovf_cnt  = r_ovf_cnt;
`else
    logic w_unused_rollback;
    assign w_unused_rollback = w_rollback;
`endif

    assign rd_data   = w_mem_q[DATA_WIDTH-1:0];
    assign rd_eop    = w_mem_q[DATA_WIDTH];
    assign rd_valid  = r_rd_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign wr_lvl    = r_wr_ptr - r_rd_ptr;
    assign rd_lvl    = r_cmt_ptr - r_rd_ptr;
    assign pkt_cnt   = r_pkt_cnt;
    assign overflow  = r_ovf;
    assign underflow = r_udf;
    assign sop_err   = r_sop_err;

    assign w_af_sum     = CW'(wr_lvl) + CW'(af_thresh);
    assign almost_full  = (w_af_sum >= DEPTH_C);
    assign almost_empty = (CW'(rd_lvl) <= CW'(ae_thresh));

endmodule

// File: tb/tb_pkt_commit_buffer.sv
// Scoreboard bench for pkt_commit_buffer at DEPTH=16.
// Expected read words are queued at write time and popped on rd_valid.
module tb_pkt_commit_buffer;
    import pkt_buf_pkg::*;

    logic        clk;
    logic        hw_rst;
    logic        sw_rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_sop;
    logic        wr_eop;
    logic        wr_drop;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_eop;
    logic        rd_valid;
    logic [4:0]  af_thresh;
    logic [4:0]  ae_thresh;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [4:0]  wr_lvl;
    logic [4:0]  rd_lvl;
    logic [4:0]  pkt_cnt;
    logic        overflow;
    logic        underflow;
    logic        sop_err;
`ifdef PKT_BUF_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] ovf_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pkt_word_t exp_q[$];
    pkt_word_t pend_q[$];

    pkt_commit_buffer #(
        .DATA_WIDTH (32),
        .DEPTH      (16),
        .TH_WIDTH   (5)
    ) dut (
        .clk          (clk),
        .hw_rst       (hw_rst),
        .sw_rst       (sw_rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_sop       (wr_sop),
        .wr_eop       (wr_eop),
        .wr_drop      (wr_drop),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_eop       (rd_eop),
        .rd_valid     (rd_valid),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .wr_lvl       (wr_lvl),
        .rd_lvl       (rd_lvl),
        .pkt_cnt      (pkt_cnt),
        .overflow     (overflow),
        .underflow    (underflow),
`ifdef PKT_BUF_STATS_EN
        .drop_cnt     (drop_cnt),
        .ovf_cnt      (ovf_cnt),
`endif
        .sop_err      (sop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        wr_sop  = 1'b0;
        wr_eop  = 1'b0;
        wr_drop = 1'b0;
        rd_en   = 1'b0;
    endtask

    task automatic drive_wr(input logic [31:0] d, input logic s,
                            input logic e);
        pkt_word_t w;
        wr_en   = 1'b1;
        wr_data = d;
        wr_sop  = s;
        wr_eop  = e;
        w.eop   = e;
        w.data  = d;
        pend_q.push_back(w);
    endtask

    task automatic commit_pend();
        while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
    endtask

    task automatic test_reset();
        n_tests++;
        if ({empty, almost_empty, full, almost_full, rd_valid, rd_eop,
             overflow, underflow, sop_err} !== 9'b110000000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 110000000",
                     {empty, almost_empty, full, almost_full, rd_valid,
                      rd_eop, overflow, underflow, sop_err});
        end
        n_tests++;
        if ({wr_lvl, rd_lvl, pkt_cnt, rd_data} !== 47'd0) begin
            n_fail++;
            $display("FAIL reset_levels: wr=%0d rd=%0d pkt=%0d data=%h expected 0",
                     wr_lvl, rd_lvl, pkt_cnt, rd_data);
        end
        drive_wr(32'h1111_0000, 1'b1, 1'b0);
        tick();
        idle();
        n_tests++;
        if (wr_lvl !== 5'd1) begin
            n_fail++;
            $display("FAIL pre_swrst_lvl: got %0d expected 1", wr_lvl);
        end
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        pend_q.delete();
        n_tests++;
        if ({wr_lvl, empty} !== {5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL swrst_clear: wr_lvl=%0d empty=%b expected 0/1",
                     wr_lvl, empty);
        end
        wr_en   = 1'b1;
        wr_data = 32'h2222_0000;
        tick();
        idle();
        n_tests++;
        if ({sop_err, wr_lvl} !== {1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL nosop_err: sop_err=%b wr_lvl=%0d expected 1/0",
                     sop_err, wr_lvl);
        end
        tick();
        n_tests++;
        if (sop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sop_err_pulse: got %b expected 0", sop_err);
        end
    endtask

    task automatic test_commit();
        pkt_word_t e;
        for (int i = 0; i < 4; i++) begin
            drive_wr(32'hA000_0000 + i, i == 0, i == 3);
            tick();
            if (i == 3) commit_pend();
            n_tests++;
            if (empty !== (i != 3)) begin
                n_fail++;
                $display("FAIL commit_empty_%0d: got %b expected %b",
                         i, empty, i != 3);
            end
        end
        idle();
        n_tests++;
        if ({rd_lvl, pkt_cnt, wr_lvl} !== {5'd4, 5'd1, 5'd4}) begin
            n_fail++;
            $display("FAIL commit_lvls: rd=%0d pkt=%0d wr=%0d expected 4/1/4",
                     rd_lvl, pkt_cnt, wr_lvl);
        end
        n_tests++;
        if ({almost_full, almost_empty} !== 2'b10) begin
            n_fail++;
            $display("FAIL commit_almost: af=%b ae=%b expected 1/0",
                     almost_full, almost_empty);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if ({rd_valid, rd_eop, rd_data} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL commit_rd_%0d: got v=%b e=%b %h expected 1 %b %h",
                         i, rd_valid, rd_eop, rd_data, e.eop, e.data);
            end
        end
        rd_en = 1'b0;
        tick();
        n_tests++;
        if ({pkt_cnt, rd_valid, empty} !== {5'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL commit_drain: pkt=%0d v=%b empty=%b expected 0/0/1",
                     pkt_cnt, rd_valid, empty);
        end
    endtask

    task automatic test_drop();
        pkt_word_t e;
        for (int i = 0; i < 3; i++) begin
            drive_wr(32'hDEAD_0000 + i, i == 0, 1'b0);
            tick();
        end
        idle();
        n_tests++;
        if ({wr_lvl, empty} !== {5'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL drop_pre: wr_lvl=%0d empty=%b expected 3/1",
                     wr_lvl, empty);
        end
        wr_en   = 1'b1;
        wr_eop  = 1'b1;
        wr_drop = 1'b1;
        tick();
        idle();
        pend_q.delete();
        n_tests++;
        if ({wr_lvl, pkt_cnt, empty} !== {5'd0, 5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL drop_rollback: wr=%0d pkt=%0d empty=%b expected 0/0/1",
                     wr_lvl, pkt_cnt, empty);
        end
        wr_drop = 1'b1;
        tick();
        idle();
        drive_wr(32'hB000_0000, 1'b1, 1'b0);
        tick();
        drive_wr(32'hB000_0001, 1'b0, 1'b1);
        tick();
        idle();
        commit_pend();
        n_tests++;
        if ({rd_lvl, pkt_cnt} !== {5'd2, 5'd1}) begin
            n_fail++;
            $display("FAIL drop_next_pkt: rd=%0d pkt=%0d expected 2/1",
                     rd_lvl, pkt_cnt);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if ({rd_valid, rd_eop, rd_data} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL drop_rd_%0d: got v=%b e=%b %h expected 1 %b %h",
                         i, rd_valid, rd_eop, rd_data, e.eop, e.data);
            end
        end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        pkt_word_t e;
        for (int i = 0; i < 16; i++) begin
            drive_wr(32'hC000_0000 + i, i == 0, 1'b0);
            tick();
        end
        idle();
        n_tests++;
        if ({full, wr_lvl, almost_full, empty} !== {1'b1, 5'd16, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_fill: full=%b wr=%0d af=%b empty=%b expected 1/16/1/1",
                     full, wr_lvl, almost_full, empty);
        end
        wr_en   = 1'b1;
        wr_data = 32'hC000_00FF;
        tick();
        idle();
        pend_q.delete();
        n_tests++;
        if ({overflow, wr_lvl, full} !== {1'b1, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_pulse: ovf=%b wr=%0d full=%b expected 1/0/0",
                     overflow, wr_lvl, full);
        end
        tick();
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_once: got %b expected 0", overflow);
        end
        wr_en  = 1'b1;
        wr_sop = 1'b1;
        tick();
        n_tests++;
        if ({wr_lvl, sop_err} !== {5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL discard_ignore: wr=%0d sop_err=%b expected 0/0",
                     wr_lvl, sop_err);
        end
        wr_sop = 1'b0;
        wr_eop = 1'b1;
        tick();
        idle();
        n_tests++;
        if ({wr_lvl, empty} !== {5'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL discard_eop: wr=%0d empty=%b expected 0/1",
                     wr_lvl, empty);
        end
        drive_wr(32'hD000_0000, 1'b1, 1'b1);
        tick();
        idle();
        commit_pend();
        n_tests++;
        if ({pkt_cnt, rd_lvl} !== {5'd1, 5'd1}) begin
            n_fail++;
            $display("FAIL ovf_recover: pkt=%0d rd=%0d expected 1/1",
                     pkt_cnt, rd_lvl);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        e = exp_q.pop_front();
        n_tests++;
        if ({rd_valid, rd_eop, rd_data} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL ovf_rd: got v=%b e=%b %h expected 1 %b %h",
                     rd_valid, rd_eop, rd_data, e.eop, e.data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        pkt_word_t e;
        drive_wr(32'hE000_0000, 1'b1, 1'b0);
        tick();
        drive_wr(32'hE000_0001, 1'b0, 1'b1);
        tick();
        idle();
        commit_pend();
        rd_en = 1'b1;
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if ({rd_valid, rd_eop, rd_data, pkt_cnt} !== {1'b1, e, 5'd1}) begin
            n_fail++;
            $display("FAIL b2b_rd0: v=%b e=%b %h pkt=%0d expected 1 %b %h 1",
                     rd_valid, rd_eop, rd_data, pkt_cnt, e.eop, e.data);
        end
        tick();
        e = exp_q.pop_front();
        n_tests++;
        if ({rd_valid, rd_eop, rd_data} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL b2b_rd1: v=%b e=%b %h expected 1 %b %h",
                     rd_valid, rd_eop, rd_data, e.eop, e.data);
        end
        tick();
        rd_en = 1'b0;
        n_tests++;
        if ({underflow, rd_valid, pkt_cnt} !== {1'b1, 1'b0, 5'd0}) begin
            n_fail++;
            $display("FAIL b2b_udf: udf=%b v=%b pkt=%0d expected 1/0/0",
                     underflow, rd_valid, pkt_cnt);
        end
        tick();
        n_tests++;
        if (underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL udf_pulse: got %b expected 0", underflow);
        end
    endtask

    task automatic test_sop_err();
        pkt_word_t e;
        drive_wr(32'hF000_0000, 1'b1, 1'b0);
        tick();
        drive_wr(32'hF000_0001, 1'b0, 1'b0);
        tick();
        pend_q.delete();
        drive_wr(32'hF000_0002, 1'b1, 1'b0);
        tick();
        n_tests++;
        if ({sop_err, wr_lvl, empty} !== {1'b1, 5'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL sop_restart: sop_err=%b wr=%0d empty=%b expected 1/1/1",
                     sop_err, wr_lvl, empty);
        end
        drive_wr(32'hF000_0003, 1'b0, 1'b1);
        tick();
        idle();
        commit_pend();
        n_tests++;
        if ({sop_err, rd_lvl, pkt_cnt} !== {1'b0, 5'd2, 5'd1}) begin
            n_fail++;
            $display("FAIL sop_commit: sop_err=%b rd=%0d pkt=%0d expected 0/2/1",
                     sop_err, rd_lvl, pkt_cnt);
        end
        rd_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = exp_q.pop_front();
            n_tests++;
            if ({rd_valid, rd_eop, rd_data} !== {1'b1, e}) begin
                n_fail++;
                $display("FAIL sop_rd_%0d: v=%b e=%b %h expected 1 %b %h",
                         i, rd_valid, rd_eop, rd_data, e.eop, e.data);
            end
        end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        pkt_word_t e;
        int  occ     = 0;
        int  written = 0;
        int  n_full  = 0;
        bit  do_wr;
        bit  do_rd;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (written >= 40 && occ == 0) break;
            do_wr = (written < 40) && (occ < 16);
            do_rd = (occ > 0) && ((written >= 40) || (cyc % 3 == 0));
            idle();
            if (do_wr) begin
                drive_wr(32'h5A00_0000 + written, 1'b1, 1'b1);
                written++;
            end
            rd_en = do_rd;
            tick();
            commit_pend();
            occ = occ + int'(do_wr) - int'(do_rd);
            if (full === 1'b1) n_full++;
            n_tests++;
            if ({full, empty} !== {occ == 16, occ == 0}) begin
                n_fail++;
                $display("FAIL wrap_flags_c%0d: full=%b empty=%b expected %b %b",
                         cyc, full, empty, occ == 16, occ == 0);
            end
            if (do_rd) begin
                e = exp_q.pop_front();
                n_tests++;
                if ({rd_valid, rd_eop, rd_data} !== {1'b1, e}) begin
                    n_fail++;
                    $display("FAIL wrap_rd_c%0d: v=%b e=%b %h expected 1 %b %h",
                             cyc, rd_valid, rd_eop, rd_data, e.eop, e.data);
                end
            end else begin
                n_tests++;
                if (rd_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_novalid_c%0d: got %b expected 0",
                             cyc, rd_valid);
                end
            end
        end
        idle();
        n_tests++;
        if (written != 40 || occ != 0 || n_full == 0) begin
            n_fail++;
            $display("FAIL wrap_coverage: written=%0d occ=%0d full_cycles=%0d",
                     written, occ, n_full);
        end
    endtask

    initial begin
        hw_rst    = 1'b0;
        sw_rst    = 1'b0;
        wr_data   = '0;
        af_thresh = 5'd13;
        ae_thresh = 5'd2;
        idle();
        repeat (3) @(posedge clk);
        #1;
        hw_rst = 1'b1;
        test_reset();
        test_commit();
        test_drop();
        test_overflow();
        test_back_to_back();
        test_sop_err();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pkt_commit_buffer.md
# pkt_commit_buffer

Store-and-forward packet buffer for the packet processor datapath: succeeds the single-pointer internal buffer by using a commit pointer, so partially written packets are never visible to the reader and are rolled back on drop without subtracting lengths. Parametrised in width, depth and threshold width. It sits between the ingress parser, which writes SOP/EOP-framed words and flags bad packets, and the egress scheduler, which reads only whole packets.

## Interface
- DATA_WIDTH, 32, payload word width
- DEPTH, 16384, word capacity; must be a power of two; ADDR_WIDTH = $clog2(DEPTH) is a localparam
- TH_WIDTH, 5, width of the almost-full and almost-empty threshold inputs
- clk  in  1  single clock; all logic on the rising edge
- hw_rst  in  1  asynchronous active-low reset
- sw_rst  in  1  synchronous active-high soft reset; same effect as hw_rst
- wr_en  in  1  write word valid
- wr_data  in  DATA_WIDTH  write word
- wr_sop / wr_eop  in  1  first and last word of a packet; both high means a one-word packet
- wr_drop  in  1  abort the packet currently being written
- rd_en  in  1  read request
- rd_data  out  DATA_WIDTH  read word
- rd_eop  out  1  last word of a packet
- rd_valid  out  1  rd_data and rd_eop are valid this cycle
- af_thresh / ae_thresh  in  TH_WIDTH  almost-full and almost-empty thresholds
- full / empty  out  1  no free word (wr_ptr vs rd_ptr) / no committed word (cmt_ptr == rd_ptr)
- almost_full / almost_empty  out  1  wr_lvl >= DEPTH-af_thresh / rd_lvl <= ae_thresh
- wr_lvl / rd_lvl  out  ADDR_WIDTH+1  occupied words including uncommitted ones / committed readable words
- pkt_cnt  out  ADDR_WIDTH+1  committed packets not yet fully read
- overflow / underflow / sop_err  out  1  one-cycle error pulses

## Operation
- Memory stores DATA_WIDTH+1 bits per word (the data plus EOP).
- Pointers wr_ptr, cmt_ptr and rd_ptr are ADDR_WIDTH+1 bits wide and carry a wrap bit.
- full = (wr_ptr[MSB] != rd_ptr[MSB]) && (the lower bits are equal).
- Write FSM has three states: IDLE, IN_PKT, DISCARD.
  - IDLE: wr_en&&wr_sop&&!full writes the word and moves to IN_PKT. If wr_eop is also set, the word commits and the FSM stays in IDLE. wr_en without sop is ignored and pulses sop_err.
  - IN_PKT: wr_en&&!full writes the word. If that word has wr_eop, cmt_ptr<=wr_ptr+1, pkt_cnt increments, and the FSM returns to IDLE.
  - IN_PKT, wr_en while full: overflow pulse, wr_ptr<=cmt_ptr, go to DISCARD, or to IDLE if the word is EOP.
  - IN_PKT, wr_drop: wr_ptr<=cmt_ptr and go to IDLE. wr_drop wins over wr_en and wr_eop in the same cycle.
  - IN_PKT, wr_sop: sop_err pulse. The old packet rolls back, and the new word is written at cmt_ptr.
  - DISCARD: every word is ignored until a word with wr_eop, then go to IDLE.
  - wr_drop in IDLE or DISCARD has no effect.
- Read: a request is accepted when rd_en&&!empty; rd_ptr increments.
  - When an accepted word has EOP, pkt_cnt decrements. If a commit happens in the same cycle, pkt_cnt is unchanged.
  - rd_en&&empty pulses underflow and leaves rd_ptr unchanged.
- Level arithmetic is modulo 2^(ADDR_WIDTH+1): wr_lvl = wr_ptr - rd_ptr and rd_lvl = cmt_ptr - rd_ptr, both combinational from the registered pointers.
- Thresholds are zero-extended before comparison.

## Timing
- Write-to-visible latency: committed words raise rd_lvl and clear empty in the cycle after the EOP write.
- Read latency is 1 cycle: rd_data, rd_eop and rd_valid are registered. rd_valid is high exactly one cycle after each accepted rd_en.
- Error pulses are registered and appear in the cycle after the causing event.
- Simultaneous read and write: both are accepted. A read frees a slot only from the next cycle, so full is evaluated on the current pointers.
- Wrap-around: pointers roll over naturally, and the MSB toggle distinguishes full from empty.
- Reset values (hw_rst low or sw_rst high): all pointers 0, FSM IDLE, pkt_cnt 0.
  - Outputs: empty=1, almost_empty=1, full=0, almost_full=0 (for af_thresh<DEPTH), rd_valid=0, rd_data=0, rd_eop=0, all pulses 0, levels 0.
  - A reset mid-packet discards everything. The memory contents are not cleared.

## Configuration
- PKT_BUF_STATS_EN defined: adds drop_cnt and ovf_cnt outputs, each 16 bits, saturating at 0xFFFF and cleared by either reset.
  - drop_cnt counts wr_drop rollbacks, sop_err rollbacks and overflow rollbacks.
  - ovf_cnt counts overflow pulses.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

## Structure
- Package pkt_buf_pkg holds the write FSM state enum (IDLE, IN_PKT, DISCARD) and the typedef of the stored word struct {eop, data}, parametrised via the DATA_WIDTH default.
- The sub-module pkt_buf_mem is a simple dual-port RAM: one write port, one registered read port, DEPTH x (DATA_WIDTH+1). The pointers, FSM and flags stay in pkt_commit_buffer.

## Test plan
- Write a 4-word packet (sop on word 0, eop on word 3) -> empty stays 1 through the write cycles and drops to 0 the cycle after the EOP word; rd_lvl=4; pkt_cnt=1.
- Write 3 words, then wr_drop -> wr_lvl returns to its previous value, pkt_cnt unchanged, empty=1; the next packet's data overwrites the dropped slots.
- DEPTH=16: fill 16 words inside one packet, then one more wr_en -> overflow pulses once, wr_lvl=0, FSM in DISCARD; the following words up to EOP are ignored.
- Read 2 words of a committed 2-word packet back-to-back -> rd_valid high 2 cycles, rd_eop on the second, pkt_cnt 1->0; a third rd_en -> underflow pulse.
- wr_sop while IN_PKT with 2 words pending -> sop_err pulse; the old words roll back and the new packet starts at cmt_ptr.
- DEPTH=16: run 40 one-word packets with interleaved reads -> data integrity across pointer wrap, and full/empty correct at the wrap boundary.
